// File: rtl/bridge_bus_arbiter.sv
// bridge_bus_arbiter: round-robin sharing of the bridge CPU port between two req/ack masters.
// Each access holds the bus for RD_LAT cycles, then acks the owner for one cycle.
module bridge_bus_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_addr,
  output logic          bus_we,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy,
  output logic          owner
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [3:0] LP_CNT = 4'(RD_LAT - 1);
  state_t        r_state, w_state;
  logic [3:0]    r_cnt, w_cnt;
  logic          r_last, w_last, r_owner, w_owner, w_win;
  logic          r_bus_we, w_bus_we, r_busy, w_busy;
  logic          r_m0_ack, w_m0_ack, r_m1_ack, w_m1_ack;
  logic [AW-1:0] r_bus_addr, w_bus_addr;
  logic [DW-1:0] r_bus_wdata, w_bus_wdata;
  logic [DW-1:0] r_m0_rdata, w_m0_rdata, r_m1_rdata, w_m1_rdata;
  always_comb begin
    w_win       = (m0_req & m1_req) ? ~r_last : m1_req;
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_last      = r_last;
    w_owner     = r_owner;
    w_bus_addr  = r_bus_addr;
    w_bus_wdata = r_bus_wdata;
    w_bus_we    = 1'b0;
    w_m0_ack    = 1'b0;
    w_m1_ack    = 1'b0;
    w_m0_rdata  = r_m0_rdata;
    w_m1_rdata  = r_m1_rdata;
    case (r_state)
      IDLE: if (m0_req | m1_req) begin
        w_state     = ACCESS;
        w_cnt       = LP_CNT;
        w_last      = w_win;
        w_owner     = w_win;
        w_bus_addr  = w_win ? m1_addr : m0_addr;
        w_bus_wdata = w_win ? m1_wdata : m0_wdata;
        w_bus_we    = w_win ? m1_we : m0_we;
      end
      ACCESS: if (r_cnt != 4'd0) begin
        w_cnt = r_cnt - 4'd1;
      end else begin
        w_state    = DONE;
        w_m0_ack   = ~r_owner;
        w_m1_ack   = r_owner;
        w_m0_rdata = r_owner ? r_m0_rdata : bus_rdata;
        w_m1_rdata = r_owner ? bus_rdata : r_m1_rdata;
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_last      <= w_last;
      r_owner     <= w_owner;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
      r_bus_we    <= w_bus_we;
      r_busy      <= w_busy;
      r_m0_ack    <= w_m0_ack;
      r_m1_ack    <= w_m1_ack;
      r_m0_rdata  <= w_m0_rdata;
      r_m1_rdata  <= w_m1_rdata;
    end
  end
  assign m0_ack    = r_m0_ack;
  assign m1_ack    = r_m1_ack;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign bus_addr  = r_bus_addr;
  assign bus_we    = r_bus_we;
  assign bus_wdata = r_bus_wdata;
  assign busy      = r_busy;
  assign owner     = r_owner;
endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// tb_bridge_bus_arbiter: three DUTs (RD_LAT 1, 3, 4) on shared stimulus, each checked
// every cycle against a transaction-timeline model.
module tb_bridge_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, bus_rdata = '0;
  int            n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    logic          m0_ack, m1_ack, bus_we, busy, owner;
    logic [DW-1:0] m0_rdata, m1_rdata, bus_wdata;
    logic [AW-1:0] bus_addr;
    bridge_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .busy(busy), .owner(owner)
    );
    // since = cycles elapsed since the grant edge, -1 when no transaction is in flight
    int            since = -1;
    bit            last = 1'b1, own = 1'b0, we_m = 1'b0, win;
    logic [AW-1:0] ea = '0;
    logic [DW-1:0] ew = '0, er0 = '0, er1 = '0;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        since = -1; last = 1'b1; own = 1'b0; we_m = 1'b0;
        ea = '0; ew = '0; er0 = '0; er1 = '0;
      end else if (since < 0) begin
        if (m0_req || m1_req) begin
          win   = (m0_req && m1_req) ? !last : m1_req;
          own   = win;
          last  = win;
          ea    = win ? m1_addr : m0_addr;
          ew    = win ? m1_wdata : m0_wdata;
          we_m  = win ? m1_we : m0_we;
          since = 0;
        end
      end else begin
        since++;
        if (since == L) begin
          if (own) er1 = bus_rdata;
          else er0 = bus_rdata;
        end
        if (since == L + 1) since = -1;
      end
    end
    always @(negedge clk) begin
      chk($sformatf("L%0d busy", L), 64'(busy), 64'(since >= 0));
      chk($sformatf("L%0d bus_we", L), 64'(bus_we), 64'(since == 0 && we_m));
      chk($sformatf("L%0d m0_ack", L), 64'(m0_ack), 64'(since == L && !own));
      chk($sformatf("L%0d m1_ack", L), 64'(m1_ack), 64'(since == L && own));
      chk($sformatf("L%0d owner", L), 64'(owner), 64'(own));
      chk($sformatf("L%0d bus_addr", L), 64'(bus_addr), 64'(ea));
      chk($sformatf("L%0d bus_wdata", L), 64'(bus_wdata), 64'(ew));
      chk($sformatf("L%0d m0_rdata", L), 64'(m0_rdata), 64'(er0));
      chk($sformatf("L%0d m1_rdata", L), 64'(m1_rdata), 64'(er1));
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(10);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100; bus_rdata = 32'hDEAD_BEEF;
    tick(2);
    m0_req = 1'b0;
    tick(8);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hFFFF_F000; m1_wdata = 32'h1234_5678;
    bus_rdata = 32'hCAFE_0001;
    tick(1);
    m1_req = 1'b0;
    tick(8);
    m0_addr = 32'h0000_0A00; m0_wdata = 32'hA5A5_A5A5; m1_we = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 30; i++) begin bus_rdata = $urandom; tick(1); end
    m1_req = 1'b0;
    for (int i = 0; i < 20; i++) begin bus_rdata = $urandom; tick(1); end
    m0_req = 1'b0;
    tick(8);
    m0_req = 1'b1; m1_req = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    m0_req = 1'b0; m1_req = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(299) != 0);
      if (m0_req) m0_req = ($urandom_range(3) != 0);
      else begin
        m0_req = $urandom_range(1); m0_we = $urandom_range(1);
        m0_addr = $urandom; m0_wdata = $urandom;
      end
      if (m1_req) m1_req = ($urandom_range(3) != 0);
      else begin
        m1_req = $urandom_range(1); m1_we = $urandom_range(1);
        m1_addr = $urandom; m1_wdata = $urandom;
      end
      bus_rdata = $urandom;
      tick(1);
    end
    rst_n = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
